// File: rtl/mem_pkg.sv
// mem_pkg: memory-op encodings, FSM states and the alignment/strobe/lane helpers
// shared by the load/store engine and the exception unit.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_LB  = 3'd0,
        MEM_LBU = 3'd1,
        MEM_LH  = 3'd2,
        MEM_LHU = 3'd3,
        MEM_LW  = 3'd4,
        MEM_SB  = 3'd5,
        MEM_SH  = 3'd6,
        MEM_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_store(mem_op_e op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic misaligned(mem_op_e op, logic [1:0] lo);
        return ((op inside {MEM_LH, MEM_LHU, MEM_SH}) && lo[0]) ||
               ((op inside {MEM_LW, MEM_SW}) && (lo != 2'b00));
    endfunction

    function automatic logic [3:0] strobe(mem_op_e op, logic [1:0] lo);
        return op == MEM_SB ? 4'b0001 << lo :
               op == MEM_SH ? (lo[1] ? 4'b1100 : 4'b0011) :
               op == MEM_SW ? 4'b1111 : 4'b0000;
    endfunction

    // Replicate the store byte/half across every lane so the strobes alone pick the target.
    function automatic logic [31:0] lane_data(mem_op_e op, logic [31:0] w);
        return op == MEM_SB ? {4{w[7:0]}} :
               op == MEM_SH ? {2{w[15:0]}} : w;
    endfunction

endpackage

// File: rtl/load_ext.sv
// load_ext: selects the addressed byte/half of a raw bus word and sign- or
// zero-extends it according to the load op.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lo_i,
    input  logic [2:0]  op_i,
    output logic [31:0] result_o
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = word_i[8*lo_i +: 8];
    assign h = lo_i[1] ? word_i[31:16] : word_i[15:0];

    assign result_o = op_i == MEM_LB  ? {{24{b[7]}}, b}  :
                      op_i == MEM_LBU ? {24'b0, b}       :
                      op_i == MEM_LH  ? {{16{h[15]}}, h} :
                      op_i == MEM_LHU ? {16'b0, h}       : word_i;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store engine driving an SRAM-like request/ack bus,
// with misalignment exceptions, flush handling and a bus watchdog.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall_req,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic [31:0] bad_vaddr,
    output logic        bus_err,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    state_e         state_q, state_d, fin_state;
    mem_op_e        op, op_q, op_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           killed_q, killed_d;
    logic [31:0]    rdata_q, rdata_d, fin_rdata, ext;
    logic           bus_err_q, bus_err_d;
    logic           data_req_q, data_req_d;
    logic           data_wr_q, data_wr_d;
    logic [3:0]     wstrb_q, wstrb_d;
    logic [31:0]    daddr_q, daddr_d;
    logic [31:0]    dwdata_q, dwdata_d;
    logic [1:0]     lo_q, lo_d;
    logic           store, live, mis, start, kill, wdog_hit;

    assign op        = mem_op_e'(mem_op);
    assign store     = is_store(op);
    assign live      = req_valid & ~flush;
    assign mis       = misaligned(op, addr[1:0]);
    assign adel      = live & mis & ~store;
    assign ades      = live & mis & store;
    assign bad_vaddr = addr;
    assign start     = (state_q == IDLE) & live & ~mis;
    assign stall_req = start | (state_q == ADDR) | (state_q == DATA);
    assign kill      = killed_q | flush;
    assign wdog_hit  = wdog_q == WDW'(TIMEOUT_CYC - 1);

    load_ext u_load_ext (
        .word_i  (data_rdata),
        .lo_i    (lo_q),
        .op_i    (op_q),
        .result_o(ext)
    );

    // A killed transaction drains on the bus but never reaches DONE or touches rdata.
    assign fin_state = kill ? IDLE : DONE;
    assign fin_rdata = (kill | data_wr_q) ? rdata_q : ext;

    always_comb begin
        state_d    = state_q;
        wdog_d     = wdog_q;
        killed_d   = killed_q;
        rdata_d    = rdata_q;
        bus_err_d  = 1'b0;
        data_req_d = 1'b0;
        data_wr_d  = data_wr_q;
        wstrb_d    = wstrb_q;
        daddr_d    = daddr_q;
        dwdata_d   = dwdata_q;
        op_d       = op_q;
        lo_d       = lo_q;
        case (state_q)
            IDLE: begin
                killed_d = 1'b0;
                if (start) begin
                    state_d    = ADDR;
                    data_req_d = 1'b1;
                    data_wr_d  = store;
                    wstrb_d    = strobe(op, addr[1:0]);
                    daddr_d    = {addr[31:2], 2'b00};
                    dwdata_d   = lane_data(op, wdata);
                    op_d       = op;
                    lo_d       = addr[1:0];
                end
            end
            ADDR: begin
                wdog_d = wdog_q + 1'b1;
                if (data_addr_ok && data_data_ok) begin
                    state_d = fin_state;
                    rdata_d = fin_rdata;
                end else if (data_addr_ok) begin
                    state_d  = DATA;
                    killed_d = flush;
                end else if (flush) begin
                    state_d = IDLE;
                end else if (wdog_hit) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end else begin
                    data_req_d = 1'b1;
                end
            end
            DATA: begin
                wdog_d = wdog_q + 1'b1;
                if (data_data_ok) begin
                    state_d = fin_state;
                    rdata_d = fin_rdata;
                end else if (wdog_hit) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end else begin
                    killed_d = kill;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) wdog_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wdog_q     <= '0;
            killed_q   <= 1'b0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            data_req_q <= 1'b0;
            data_wr_q  <= 1'b0;
            wstrb_q    <= '0;
            daddr_q    <= '0;
            dwdata_q   <= '0;
            op_q       <= MEM_LB;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            killed_q   <= killed_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            data_req_q <= data_req_d;
            data_wr_q  <= data_wr_d;
            wstrb_q    <= wstrb_d;
            daddr_q    <= daddr_d;
            dwdata_q   <= dwdata_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
        end
    end

    assign rdata      = rdata_q;
    assign bus_err    = bus_err_q;
    assign data_req   = data_req_q;
    assign data_wr    = data_wr_q;
    assign data_wstrb = wstrb_q;
    assign data_addr  = daddr_q;
    assign data_wdata = dwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: schedule-driven bench; each transaction's bus timing is chosen up
// front and the expected outputs per cycle are derived from that schedule.
module tb_mem_access_unit;

    localparam int TO    = 8;
    localparam int NEVER = 99;

    logic        clk = 1'b0;
    logic        rst, req_valid, flush, data_addr_ok, data_data_ok;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata, data_rdata;
    logic        stall_req, adel, ades, bus_err, data_req, data_wr;
    logic [31:0] rdata, bad_vaddr, data_addr, data_wdata;
    logic [3:0]  data_wstrb;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_op(mem_op), .addr(addr),
        .wdata(wdata), .flush(flush), .stall_req(stall_req), .rdata(rdata), .adel(adel),
        .ades(ades), .bad_vaddr(bad_vaddr), .bus_err(bus_err), .data_req(data_req),
        .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    int          n_cmp = 0, n_bad = 0;
    bit          chk_en = 0;
    logic        e_stall, e_req, e_berr, e_adel, e_ades, e_wr;
    logic [31:0] m_rdata, e_bad, e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    int          c_stall = 0, c_req = 0, c_berr = 0, c_adel = 0, c_ades = 0;
    logic [31:0] cap_bad = 0, cap_wdata = 0;
    logic [3:0]  cap_wstrb = 0;
    logic        cap_wr = 0;

    function automatic bit is_st(int op);
        return op >= 5;
    endfunction

    function automatic bit misal(int op, logic [31:0] a);
        int size;
        size = (op == 0 || op == 1 || op == 5) ? 1 : (op == 4 || op == 7) ? 4 : 2;
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] ld_val(int op, logic [31:0] a, logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (op == 0) return b >= 128 ? (b | 32'hFFFFFF00) : b;
        if (op == 1) return b;
        if (op == 2) return h >= 32768 ? (h | 32'hFFFF0000) : h;
        if (op == 3) return h;
        return w;
    endfunction

    function automatic logic [3:0] strb(int op, logic [31:0] a);
        if (op == 5) return 4'(1 << (a % 4));
        if (op == 6) return (a % 4) >= 2 ? 4'b1100 : 4'b0011;
        if (op == 7) return 4'b1111;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] lane(int op, logic [31:0] w);
        if (op == 5) return {4{w[7:0]}};
        if (op == 6) return {2{w[15:0]}};
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Compare on the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            chk("stall_req", 32'(stall_req), 32'(e_stall));
            chk("data_req", 32'(data_req), 32'(e_req));
            chk("bus_err", 32'(bus_err), 32'(e_berr));
            chk("adel", 32'(adel), 32'(e_adel));
            chk("ades", 32'(ades), 32'(e_ades));
            chk("rdata", rdata, m_rdata);
            if (e_adel || e_ades) chk("bad_vaddr", bad_vaddr, e_bad);
            if (e_req) begin
                chk("data_wr", 32'(data_wr), 32'(e_wr));
                chk("data_wstrb", 32'(data_wstrb), 32'(e_wstrb));
                chk("data_addr", data_addr, e_addr);
                if (e_wr) chk("data_wdata", data_wdata, e_wdata);
            end
        end
        c_stall += int'(stall_req);
        c_req   += int'(data_req);
        c_berr  += int'(bus_err);
        c_adel  += int'(adel);
        c_ades  += int'(ades);
        if (data_req) begin
            cap_wstrb = data_wstrb;
            cap_wdata = data_wdata;
            cap_wr    = data_wr;
        end
        if (adel || ades) cap_bad = bad_vaddr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 0; flush = 0; mem_op = 3'($urandom_range(0, 7)); addr = $urandom;
        wdata = $urandom; data_addr_ok = 0; data_data_ok = 0; data_rdata = $urandom;
        e_stall = 0; e_req = 0; e_berr = 0; e_adel = 0; e_ades = 0;
        tick();
    endtask

    // al/dl: addr_ok latency and extra data_ok latency (NEVER = no ack),
    // fl: flush cycle, rs: cycle with reset held low (-1 = none).
    task automatic txn(input int op, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] rw, input int al, input int dl, input int fl,
                       input int rs);
        int ac, dc, last, send, reqend;
        bit mis, tmo, nrm;
        ac = 1 + al; dc = ac + dl; mis = misal(op, a); tmo = 0; nrm = 0;
        if (mis || fl == 0) begin last = 0; send = -1; end
        else if (rs > 0) begin last = rs + 1; send = rs; end
        else if (fl > 0 && fl < ac && fl <= TO) begin last = fl; send = fl; end
        else if (dc > TO) begin tmo = 1; last = TO + 1; send = TO; end
        else if (fl >= ac && fl <= dc) begin last = dc; send = dc; end
        else begin nrm = 1; last = dc + 1; send = dc; end
        reqend = ac < send ? ac : send;
        for (int k = 0; k <= last; k++) begin
            rst          = (k != rs);
            req_valid    = (k == 0) || (fl >= 0 ? k <= fl : k < last);
            flush        = (k == fl);
            mem_op       = 3'(op);
            addr         = a;
            wdata        = w;
            data_addr_ok = (k == ac) && (ac <= send);
            data_data_ok = (k == dc) && (dc <= send);
            data_rdata   = (k == dc) ? rw : $urandom;
            e_stall = k <= send;
            e_req   = k >= 1 && k <= reqend;
            e_berr  = tmo && k == TO + 1;
            e_adel  = req_valid && !flush && mis && !is_st(op);
            e_ades  = req_valid && !flush && mis && is_st(op);
            e_bad   = a;
            e_wr    = is_st(op);
            e_wstrb = strb(op, a);
            e_addr  = a & ~32'd3;
            e_wdata = lane(op, w);
            if (nrm && k == dc + 1 && !is_st(op)) m_rdata = ld_val(op, a, rw);
            if ((tmo && k == TO + 1) || (rs > 0 && k == rs + 1)) m_rdata = '0;
            tick();
        end
        rst = 1;
    endtask

    initial begin
        int s0, r0, b0, a0, op, al, dl, fl;
        logic [31:0] a;
        rst = 0; req_valid = 0; flush = 0; mem_op = 0; addr = 0; wdata = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0; m_rdata = 0;
        e_stall = 0; e_req = 0; e_berr = 0; e_adel = 0; e_ades = 0;
        e_wr = 0; e_wstrb = 0; e_bad = 0; e_addr = 0; e_wdata = 0;
        @(posedge clk);
        #1;
        chk_en = 1;
        idle();
        idle();
        rst = 1;
        idle();

        s0 = c_stall;
        txn(4, 32'h100, 0, 32'hDEADBEEF, 0, 0, -1, -1);
        chk("lit_lw_stall_cycles", 32'(c_stall - s0), 2);
        chk("lit_lw_rdata", rdata, 32'hDEADBEEF);
        txn(0, 32'h103, 0, 32'h80123456, 1, 0, -1, -1);
        chk("lit_lb_rdata", rdata, 32'hFFFFFF80);
        txn(1, 32'h103, 0, 32'h80123456, 0, 2, -1, -1);
        chk("lit_lbu_rdata", rdata, 32'h00000080);
        txn(3, 32'h102, 0, 32'hABCD1234, 0, 0, -1, -1);
        chk("lit_lhu_rdata", rdata, 32'h0000ABCD);

        s0 = c_stall;
        txn(4, 32'h100, 0, 32'h11111111, 2, 3, 4, -1);
        chk("lit_flush_stall_cycles", 32'(c_stall - s0), 7);
        chk("lit_flush_rdata", rdata, 32'h0000ABCD);

        txn(5, 32'h101, 32'h000000A5, 0, 1, 1, -1, -1);
        chk("lit_sb_wstrb", 32'(cap_wstrb), 32'b0010);
        chk("lit_sb_wdata", cap_wdata, 32'hA5A5A5A5);
        chk("lit_sb_wr", 32'(cap_wr), 1);
        txn(6, 32'h102, 32'h1234BEEF, 0, 0, 1, -1, -1);
        chk("lit_sh_wstrb", 32'(cap_wstrb), 32'b1100);

        a0 = c_adel; r0 = c_req; s0 = c_stall;
        txn(4, 32'h102, 0, 0, 0, 0, -1, -1);
        chk("lit_adel_seen", 32'(c_adel - a0), 1);
        chk("lit_adel_vaddr", cap_bad, 32'h102);
        chk("lit_adel_no_req", 32'(c_req - r0), 0);
        chk("lit_adel_no_stall", 32'(c_stall - s0), 0);
        a0 = c_ades;
        txn(6, 32'h101, 0, 0, 0, 0, -1, -1);
        chk("lit_ades_seen", 32'(c_ades - a0), 1);

        b0 = c_berr; r0 = c_req;
        txn(4, 32'h300, 0, 0, NEVER, 0, -1, -1);
        chk("lit_tmo_bus_err", 32'(c_berr - b0), 1);
        chk("lit_tmo_req_cycles", 32'(c_req - r0), 8);
        chk("lit_tmo_rdata", rdata, 0);
        txn(4, 32'h200, 0, 32'hCAFEF00D, 1, 1, -1, -1);
        chk("lit_after_tmo_rdata", rdata, 32'hCAFEF00D);

        r0 = c_req;
        txn(4, 32'h400, 0, 0, NEVER, 0, -1, 2);
        chk("lit_rst_req_cycles", 32'(c_req - r0), 2);
        chk("lit_rst_rdata", rdata, 0);
        idle();

        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 7);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            al = $urandom_range(0, 9) == 0 ? NEVER : $urandom_range(0, 3);
            dl = $urandom_range(0, 9) == 0 ? NEVER : $urandom_range(0, 3);
            fl = $urandom_range(0, 4) == 0 ? $urandom_range(0, 6) : -1;
            txn(op, a, $urandom, $urandom, al, dl, fl, -1);
            if ($urandom_range(0, 1) != 0) idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
